memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage directly downstream of execute. Consumes the execute/memory pipeline register.
- Performs data loads and stores over a single-outstanding valid/ready data bus.
- Aligns and sign-extends load data, and detects misaligned and faulting accesses.
- Raises a stall request to the hazard unit until the access completes, then registers results into the memory/writeback pipeline register.

Parameters:
- None. Fixed 32-bit datapath.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- pc_in, next_pc_in  in  32  from execute
- alu_data_in  in  32  effective address / ALU result
- rs2_data_in  in  32  store data
- csr_data_in  in  32  CSR read value
- branch_taken_in, load_in, store_in, load_signed_in, bypass_memory_in, csr_write_in, mret_in, wfi_in  in  1 each  control
- load_store_size_in  in  2  00 byte, 01 half, 10 word
- write_select_in  in  2  writeback select
- rd_address_in  in  5  destination register
- csr_address_in  in  12  CSR address
- valid_in, exception_in  in  1  from execute
- ecause_in  in  4  from execute
- stall, invalidate  in  1  from hazard
- mem_stall_out  out  1  to hazard; access pending
- mem_req  out  1  bus request valid
- mem_write  out  1  1 = store
- mem_addr  out  32  word-aligned address ({alu_data_in[31:2],2'b00})
- mem_wdata  out  32  store data replicated to lanes
- mem_wstrb  out  4  byte enables
- mem_ready  in  1  request accepted
- mem_rvalid  in  1  response valid
- mem_rdata  in  32  read data
- mem_error  in  1  bus fault, qualified by mem_rvalid
- pc_out, next_pc_out, alu_data_out, load_data_out, csr_data_out  out  32  to writeback
- branch_taken_out, csr_write_out, mret_out, wfi_out, valid_out, exception_out  out  1  to writeback
- write_select_out  out  2  to writeback
- rd_address_out  out  5  to writeback
- csr_address_out  out  12  to writeback
- ecause_out  out  4  to writeback

Behaviour:
- Reset (async): state IDLE; all outputs and registers 0; mem_req 0.
- Access condition: valid_in && (load_in || store_in) && !bypass_memory_in && !exception_in && aligned.
  - Aligned rules: half requires addr[0]=0; word requires addr[1:0]=0.
- Misaligned access: no bus request. Exception is registered: ecause 4 for load, 6 for store; exception_out 1.
- Store lanes:
  - Byte: wdata = {4{rs2[7:0]}}, wstrb = 1<<addr[1:0].
  - Half: wdata = {2{rs2[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - Word: wdata = rs2, wstrb = 1111.
  - Loads: wstrb 0000.
- FSM states:
  - IDLE: if access condition && !invalidate, mem_req=1 combinationally and mem_stall_out=1. Go to WAIT if mem_ready, else REQ.
  - REQ: mem_req=1 with address, data and strobes held stable; mem_stall_out=1. Go to WAIT on mem_ready.
  - WAIT: mem_req=0, mem_stall_out=1. On mem_rvalid: capture aligned load data and mem_error into a result buffer, drop mem_stall_out that same cycle, go to DONE if stall is still 1, else to IDLE with the output register loaded directly.
  - DONE: mem_stall_out=0. When !stall, load the output register from the buffer and go to IDLE. No re-issue.
- Load alignment: select byte/half by addr[1:0]; zero- or sign-extend per load_signed_in.
- Output register update, when !stall (or on FSM completion as above):
  - valid_out = valid_in && !invalidate && !killed.
  - Other fields are copied; non-memory ops pass through with 1-cycle latency.
- Exception priority: exception_in, then misalign, then mem_error (ecause 5 load fault, 7 store fault).
- invalidate in IDLE suppresses the request. invalidate in REQ/WAIT sets a kill flag: the bus transaction completes (single outstanding, no cancel) and the result is delivered with valid_out=0. The kill flag clears on return to IDLE.
- Minimum access latency: request accepted on the cycle it is issued, rvalid the next cycle, giving 2 cycles with mem_stall_out high for 1 cycle.
- mem_req never asserted while a response is outstanding.

Test Plan:
- LW at 0x100, mem_ready=1 immediately, rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x100, wstrb=0000, mem_stall_out high 1 cycle, load_data_out=0xDEADBEEF, valid_out=1.
- LB signed at 0x103, rdata=0x80FF1234 -> load_data_out=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x202, rs2=0x0000ABCD, mem_ready delayed 3 cycles -> mem_req held 4 cycles with stable addr 0x200, wdata=0xABCDABCD, wstrb=1100.
- LW at 0x101 -> no mem_req; exception_out=1, ecause_out=4. SW at 0x102 -> ecause_out=6.
- Load with mem_error on rvalid -> exception_out=1, ecause_out=5. invalidate asserted during WAIT -> transaction completes, valid_out=0.
- Reset asserted during WAIT -> all outputs 0 immediately, state IDLE; the next load issues normally.

Source files
------------

// File: rtl/memory_stage.sv
// ============================================================================
// Module   : memory_stage
// Purpose  : Load/store stage between execute and writeback. Single-outstanding
//            valid/ready data bus, load alignment, misalign and bus-fault traps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] csr_data_in,
    input  logic        branch_taken_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic        load_signed_in,
    input  logic        bypass_memory_in,
    input  logic        csr_write_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic [1:0]  load_store_size_in,
    input  logic [1:0]  write_select_in,
    input  logic [4:0]  rd_address_in,
    input  logic [11:0] csr_address_in,
    input  logic        valid_in,
    input  logic        exception_in,
    input  logic [3:0]  ecause_in,
    input  logic        stall,
    input  logic        invalidate,
    output logic        mem_stall_out,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] load_data_out,
    output logic [31:0] csr_data_out,
    output logic        branch_taken_out,
    output logic        csr_write_out,
    output logic        mret_out,
    output logic        wfi_out,
    output logic        valid_out,
    output logic        exception_out,
    output logic [1:0]  write_select_out,
    output logic [4:0]  rd_address_out,
    output logic [11:0] csr_address_out,
    output logic [3:0]  ecause_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] alu_data;
        logic [31:0] load_data;
        logic [31:0] csr_data;
        logic        branch_taken;
        logic        csr_write;
        logic        mret;
        logic        wfi;
        logic        valid;
        logic        exception;
        logic [1:0]  write_select;
        logic [4:0]  rd_address;
        logic [11:0] csr_address;
        logic [3:0]  ecause;
    } wb_t;

    logic [1:0]  state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic        req_write_q, req_write_d;
    logic [1:0]  req_size_q, req_size_d;
    logic        req_signed_q, req_signed_d;
    logic [1:0]  req_off_q, req_off_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        buf_err_q, buf_err_d;
    wb_t         out_q, out_d;

    logic        w_aligned, w_mem_op, w_misalign, w_issue;
    logic [31:0] w_wdata, w_load_aligned, w_res_data;
    logic [3:0]  w_wstrb;
    logic        w_res_err;
    wb_t         w_pass, w_result;

    function automatic logic [31:0] align_load(input logic [31:0] data, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = off[1] ? data[31:16] : data[15:0];
        case (size)
            SZ_BYTE: align_load = {{24{sgn & b[7]}}, b};
            SZ_HALF: align_load = {{16{sgn & h[15]}}, h};
            default: align_load = data;
        endcase
    endfunction

    // Access decode and store lane steering from the execute/memory register
    always_comb begin
        case (load_store_size_in)
            SZ_HALF: w_aligned = ~alu_data_in[0];
            SZ_WORD: w_aligned = (alu_data_in[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
        w_mem_op   = valid_in && (load_in || store_in) && !bypass_memory_in && !exception_in;
        w_misalign = w_mem_op && !w_aligned;
        w_issue    = (state_q == S_IDLE) && w_mem_op && w_aligned && !invalidate;
        case (load_store_size_in)
            SZ_BYTE: begin
                w_wdata = {4{rs2_data_in[7:0]}};
                w_wstrb = 4'b0001 << alu_data_in[1:0];
            end
            SZ_HALF: begin
                w_wdata = {2{rs2_data_in[15:0]}};
                w_wstrb = alu_data_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = rs2_data_in;
                w_wstrb = 4'b1111;
            end
        endcase
        if (!store_in) w_wstrb = 4'b0000;
    end

    always_comb begin
        w_pass              = '0;
        w_pass.pc           = pc_in;
        w_pass.next_pc      = next_pc_in;
        w_pass.alu_data     = alu_data_in;
        w_pass.csr_data     = csr_data_in;
        w_pass.branch_taken = branch_taken_in;
        w_pass.csr_write    = csr_write_in;
        w_pass.mret         = mret_in;
        w_pass.wfi          = wfi_in;
        w_pass.valid        = valid_in && !invalidate;
        w_pass.exception    = exception_in || w_misalign;
        w_pass.write_select = write_select_in;
        w_pass.rd_address   = rd_address_in;
        w_pass.csr_address  = csr_address_in;
        w_pass.ecause       = w_misalign ? (store_in ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN)
                                         : ecause_in;

        w_load_aligned = req_write_q ? 32'd0
                                     : align_load(mem_rdata, req_off_q, req_size_q, req_signed_q);
        w_res_data     = (state_q == S_DONE) ? buf_data_q : w_load_aligned;
        w_res_err      = (state_q == S_DONE) ? buf_err_q  : mem_error;

        w_result           = w_pass;
        w_result.valid     = w_pass.valid && !kill_q;
        w_result.load_data = w_res_data;
        if (w_res_err && !exception_in) begin
            w_result.exception = 1'b1;
            w_result.ecause    = req_write_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            S_IDLE: if (w_issue) state_d = mem_ready ? S_WAIT : S_REQ;
            S_REQ: begin
                if (invalidate) kill_d = 1'b1;
                if (mem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (invalidate) kill_d = 1'b1;
                if (mem_rvalid) state_d = stall ? S_DONE : S_IDLE;
            end
            default: begin
                if (invalidate) kill_d = 1'b1;
                if (!stall) state_d = S_IDLE;
            end
        endcase
        if (state_d == S_IDLE) kill_d = 1'b0;
    end

    // FSM: outputs; bus fields are zero whenever no request is presented
    always_comb begin
        mem_req       = w_issue || (state_q == S_REQ);
        mem_stall_out = w_issue || (state_q == S_REQ) || ((state_q == S_WAIT) && !mem_rvalid);
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        mem_write     = 1'b0;
        if (state_q == S_REQ) begin
            mem_addr  = req_addr_q;
            mem_wdata = req_wdata_q;
            mem_wstrb = req_wstrb_q;
            mem_write = req_write_q;
        end else if (w_issue) begin
            mem_addr  = {alu_data_in[31:2], 2'b00};
            mem_wdata = w_wdata;
            mem_wstrb = w_wstrb;
            mem_write = store_in;
        end
    end

    always_comb begin
        out_d        = out_q;
        buf_data_d   = buf_data_q;
        buf_err_d    = buf_err_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_wstrb_d  = req_wstrb_q;
        req_write_d  = req_write_q;
        req_size_d   = req_size_q;
        req_signed_d = req_signed_q;
        req_off_d    = req_off_q;
        case (state_q)
            S_IDLE: begin
                if (w_issue) begin
                    req_addr_d   = {alu_data_in[31:2], 2'b00};
                    req_wdata_d  = w_wdata;
                    req_wstrb_d  = w_wstrb;
                    req_write_d  = store_in;
                    req_size_d   = load_store_size_in;
                    req_signed_d = load_signed_in;
                    req_off_d    = alu_data_in[1:0];
                end else if (!stall) begin
                    out_d = w_pass;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    buf_data_d = w_load_aligned;
                    buf_err_d  = mem_error;
                    if (!stall) out_d = w_result;
                end
            end
            S_DONE: if (!stall) out_d = w_result;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            buf_data_q   <= '0;
            buf_err_q    <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
            req_write_q  <= 1'b0;
            req_size_q   <= '0;
            req_signed_q <= 1'b0;
            req_off_q    <= '0;
        end else begin
            out_q        <= out_d;
            buf_data_q   <= buf_data_d;
            buf_err_q    <= buf_err_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_wstrb_q  <= req_wstrb_d;
            req_write_q  <= req_write_d;
            req_size_q   <= req_size_d;
            req_signed_q <= req_signed_d;
            req_off_q    <= req_off_d;
        end
    end

    assign pc_out           = out_q.pc;
    assign next_pc_out      = out_q.next_pc;
    assign alu_data_out     = out_q.alu_data;
    assign load_data_out    = out_q.load_data;
    assign csr_data_out     = out_q.csr_data;
    assign branch_taken_out = out_q.branch_taken;
    assign csr_write_out    = out_q.csr_write;
    assign mret_out         = out_q.mret;
    assign wfi_out          = out_q.wfi;
    assign valid_out        = out_q.valid;
    assign exception_out    = out_q.exception;
    assign write_select_out = out_q.write_select;
    assign rd_address_out   = out_q.rd_address;
    assign csr_address_out  = out_q.csr_address;
    assign ecause_out       = out_q.ecause;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// Module   : tb_memory_stage
// Purpose  : Directed self-checking bench for memory_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
    logic        branch_taken_in, load_in, store_in, load_signed_in, bypass_memory_in;
    logic        csr_write_in, mret_in, wfi_in;
    logic [1:0]  load_store_size_in, write_select_in;
    logic [4:0]  rd_address_in;
    logic [11:0] csr_address_in;
    logic        valid_in, exception_in;
    logic [3:0]  ecause_in;
    logic        stall, invalidate, hold_stall;
    logic        mem_stall_out, mem_req, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_rvalid, mem_error;
    logic [31:0] mem_rdata;
    logic [31:0] pc_out, next_pc_out, alu_data_out, load_data_out, csr_data_out;
    logic        branch_taken_out, csr_write_out, mret_out, wfi_out, valid_out, exception_out;
    logic [1:0]  write_select_out;
    logic [4:0]  rd_address_out;
    logic [11:0] csr_address_out;
    logic [3:0]  ecause_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Hazard unit model: stall whenever the stage reports a pending access
    assign stall = mem_stall_out | hold_stall;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .next_pc_in(next_pc_in),
        .alu_data_in(alu_data_in), .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
        .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
        .load_signed_in(load_signed_in), .bypass_memory_in(bypass_memory_in),
        .csr_write_in(csr_write_in), .mret_in(mret_in), .wfi_in(wfi_in),
        .load_store_size_in(load_store_size_in), .write_select_in(write_select_in),
        .rd_address_in(rd_address_in), .csr_address_in(csr_address_in),
        .valid_in(valid_in), .exception_in(exception_in), .ecause_in(ecause_in),
        .stall(stall), .invalidate(invalidate), .mem_stall_out(mem_stall_out),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
        .load_data_out(load_data_out), .csr_data_out(csr_data_out),
        .branch_taken_out(branch_taken_out), .csr_write_out(csr_write_out),
        .mret_out(mret_out), .wfi_out(wfi_out), .valid_out(valid_out),
        .exception_out(exception_out), .write_select_out(write_select_out),
        .rd_address_out(rd_address_out), .csr_address_out(csr_address_out),
        .ecause_out(ecause_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_op();
        valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0; load_signed_in = 1'b0;
        bypass_memory_in = 1'b0; exception_in = 1'b0; branch_taken_in = 1'b0;
        invalidate = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_error = 1'b0;
        mem_rdata = 32'd0;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
        valid_in = 1'b1; load_in = ld; store_in = st; load_store_size_in = size;
        load_signed_in = sgn; alu_data_in = addr; rs2_data_in = wd;
    endtask

    // Minimum-latency access; returns at the negedge after the result is registered
    task automatic run_mem(input logic ld, input logic st, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input logic err);
        step();
        drive_op(ld, st, size, sgn, addr, wd);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata; mem_error = err;
        step();
        clear_op();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_op();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %0b expected 0", mem_req); end
        n_checks++; if (mem_stall_out !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b expected 0", mem_stall_out); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", valid_out); end
        n_checks++; if (pc_out !== 32'd0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", pc_out); end
        n_checks++; if (ecause_out !== 4'd0) begin n_fail++; $display("FAIL rst_ecause: got %h expected 0", ecause_out); end
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        step();
        valid_in = 1'b1; pc_in = 32'h44; next_pc_in = 32'h48; rd_address_in = 5'd5;
        csr_data_in = 32'hC5; write_select_in = 2'd2; branch_taken_in = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL pass_req: got %0b expected 0", mem_req); end
        step();
        clear_op();
        @(negedge clk);
        n_checks++; if (pc_out !== 32'h44) begin n_fail++; $display("FAIL pass_pc: got %h expected 44", pc_out); end
        n_checks++; if (next_pc_out !== 32'h48) begin n_fail++; $display("FAIL pass_npc: got %h expected 48", next_pc_out); end
        n_checks++; if (rd_address_out !== 5'd5) begin n_fail++; $display("FAIL pass_rd: got %0d expected 5", rd_address_out); end
        n_checks++; if (csr_data_out !== 32'hC5) begin n_fail++; $display("FAIL pass_csr: got %h expected c5", csr_data_out); end
        n_checks++; if (write_select_out !== 2'd2) begin n_fail++; $display("FAIL pass_wsel: got %0d expected 2", write_select_out); end
        n_checks++; if (branch_taken_out !== 1'b1) begin n_fail++; $display("FAIL pass_br: got %0b expected 1", branch_taken_out); end
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL pass_valid: got %0b expected 1", valid_out); end
    endtask

    task automatic test_load_word();
        step();
        pc_in = 32'h1000;
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL lw_req: got %0b expected 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h expected 100", mem_addr); end
        n_checks++; if (mem_wstrb !== 4'b0000) begin n_fail++; $display("FAIL lw_wstrb: got %b expected 0000", mem_wstrb); end
        n_checks++; if (mem_stall_out !== 1'b1) begin n_fail++; $display("FAIL lw_stall1: got %0b expected 1", mem_stall_out); end
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++; if (mem_stall_out !== 1'b0) begin n_fail++; $display("FAIL lw_stall2: got %0b expected 0", mem_stall_out); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL lw_req_wait: got %0b expected 0", mem_req); end
        step();
        clear_op();
        @(negedge clk);
        n_checks++; if (load_data_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", load_data_out); end
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL lw_valid: got %0b expected 1", valid_out); end
        n_checks++; if (pc_out !== 32'h1000) begin n_fail++; $display("FAIL lw_pc: got %h expected 1000", pc_out); end
        n_checks++; if (exception_out !== 1'b0) begin n_fail++; $display("FAIL lw_exc: got %0b expected 0", exception_out); end
    endtask

    task automatic test_load_byte();
        run_mem(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 1'b0);
        n_checks++; if (load_data_out !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", load_data_out); end
        run_mem(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 1'b0);
        n_checks++; if (load_data_out !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h expected 00000080", load_data_out); end
        run_mem(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80FF1234, 1'b0);
        n_checks++; if (load_data_out !== 32'h000080FF) begin n_fail++; $display("FAIL lhu_data: got %h expected 000080ff", load_data_out); end
    endtask

    task automatic test_store_half();
        step();
        drive_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL sh_req[%0d]: got %0b expected 1", i, mem_req); end
            n_checks++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL sh_addr[%0d]: got %h expected 200", i, mem_addr); end
            n_checks++; if (mem_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata[%0d]: got %h expected abcdabcd", i, mem_wdata); end
            n_checks++; if (mem_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb[%0d]: got %b expected 1100", i, mem_wstrb); end
            n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL sh_write[%0d]: got %0b expected 1", i, mem_write); end
            step();
        end
        mem_ready = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL sh_req_wait: got %0b expected 0", mem_req); end
        step();
        clear_op();
        @(negedge clk);
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL sh_valid: got %0b expected 1", valid_out); end
        n_checks++; if (exception_out !== 1'b0) begin n_fail++; $display("FAIL sh_exc: got %0b expected 0", exception_out); end
        step();
        drive_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h0000005A);
        @(negedge clk);
        n_checks++; if (mem_wstrb !== 4'b0010) begin n_fail++; $display("FAIL sb_wstrb: got %b expected 0010", mem_wstrb); end
        n_checks++; if (mem_wdata !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL sb_wdata: got %h expected 5a5a5a5a", mem_wdata); end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1;
        step();
        clear_op();
    endtask

    task automatic test_misaligned();
        step();
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_lw_req: got %0b expected 0", mem_req); end
        n_checks++; if (mem_stall_out !== 1'b0) begin n_fail++; $display("FAIL mis_lw_stall: got %0b expected 0", mem_stall_out); end
        step();
        drive_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0);
        @(negedge clk);
        n_checks++; if (exception_out !== 1'b1) begin n_fail++; $display("FAIL mis_lw_exc: got %0b expected 1", exception_out); end
        n_checks++; if (ecause_out !== 4'd4) begin n_fail++; $display("FAIL mis_lw_cause: got %0d expected 4", ecause_out); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_sw_req: got %0b expected 0", mem_req); end
        step();
        clear_op();
        @(negedge clk);
        n_checks++; if (ecause_out !== 4'd6) begin n_fail++; $display("FAIL mis_sw_cause: got %0d expected 6", ecause_out); end
        n_checks++; if (exception_out !== 1'b1) begin n_fail++; $display("FAIL mis_sw_exc: got %0b expected 1", exception_out); end
    endtask

    task automatic test_mem_error();
        run_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0000CAFE, 1'b1);
        n_checks++; if (exception_out !== 1'b1) begin n_fail++; $display("FAIL err_ld_exc: got %0b expected 1", exception_out); end
        n_checks++; if (ecause_out !== 4'd5) begin n_fail++; $display("FAIL err_ld_cause: got %0d expected 5", ecause_out); end
        run_mem(1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'h11, 32'h0, 1'b1);
        n_checks++; if (ecause_out !== 4'd7) begin n_fail++; $display("FAIL err_st_cause: got %0d expected 7", ecause_out); end
    endtask

    task automatic test_invalidate();
        step();
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        invalidate = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL inv_idle_req: got %0b expected 0", mem_req); end
        step();
        clear_op();
        @(negedge clk);
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL inv_idle_valid: got %0b expected 0", valid_out); end
        step();
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; invalidate = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_stall_out !== 1'b1) begin n_fail++; $display("FAIL inv_wait_stall: got %0b expected 1", mem_stall_out); end
        step();
        invalidate = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
        step();
        clear_op();
        @(negedge clk);
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL inv_wait_valid: got %0b expected 0", valid_out); end
        n_checks++; if (load_data_out !== 32'h55) begin n_fail++; $display("FAIL inv_wait_data: got %h expected 55", load_data_out); end
    endtask

    task automatic test_done_path();
        step();
        valid_in = 1'b1; pc_in = 32'h600;
        step();
        clear_op();
        hold_stall = 1'b1;
        drive_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80010000;
        @(negedge clk);
        n_checks++; if (mem_stall_out !== 1'b0) begin n_fail++; $display("FAIL done_stall: got %0b expected 0", mem_stall_out); end
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL done_reissue: got %0b expected 0", mem_req); end
        n_checks++; if (load_data_out !== 32'd0) begin n_fail++; $display("FAIL done_hold: got %h expected 0", load_data_out); end
        step();
        hold_stall = 1'b0;
        @(negedge clk);
        n_checks++; if (load_data_out !== 32'd0) begin n_fail++; $display("FAIL done_hold2: got %h expected 0", load_data_out); end
        step();
        clear_op();
        @(negedge clk);
        n_checks++; if (load_data_out !== 32'hFFFF8001) begin n_fail++; $display("FAIL done_data: got %h expected ffff8001", load_data_out); end
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL done_valid: got %0b expected 1", valid_out); end
    endtask

    task automatic test_reset_in_wait();
        step();
        valid_in = 1'b1; pc_in = 32'h500;
        step();
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        n_checks++; if (pc_out !== 32'h500) begin n_fail++; $display("FAIL rw_pre_pc: got %h expected 500", pc_out); end
        n_checks++; if (mem_stall_out !== 1'b1) begin n_fail++; $display("FAIL rw_pre_stall: got %0b expected 1", mem_stall_out); end
        clear_op();
        reset = 1'b1;
        #1;
        n_checks++; if (pc_out !== 32'd0) begin n_fail++; $display("FAIL rw_pc: got %h expected 0", pc_out); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rw_valid: got %0b expected 0", valid_out); end
        n_checks++; if (mem_stall_out !== 1'b0) begin n_fail++; $display("FAIL rw_stall: got %0b expected 0", mem_stall_out); end
        step();
        reset = 1'b0;
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rw_req: got %0b expected 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h104) begin n_fail++; $display("FAIL rw_addr: got %h expected 104", mem_addr); end
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        step();
        clear_op();
        @(negedge clk);
        n_checks++; if (load_data_out !== 32'h12345678) begin n_fail++; $display("FAIL rw_data: got %h expected 12345678", load_data_out); end
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL rw_valid2: got %0b expected 1", valid_out); end
    endtask

    initial begin
        reset = 1'b1; hold_stall = 1'b0;
        pc_in = '0; next_pc_in = '0; alu_data_in = '0; rs2_data_in = '0; csr_data_in = '0;
        csr_write_in = 1'b0; mret_in = 1'b0; wfi_in = 1'b0; load_store_size_in = '0;
        write_select_in = '0; rd_address_in = '0; csr_address_in = '0; ecause_in = '0;
        clear_op();
        test_reset();
        test_passthrough();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_mem_error();
        test_invalidate();
        test_done_path();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire
